// File: rtl/latch_bank_reader.sv
// rtl/latch_bank_reader.sv - synchronizes a gated-latch bank, qualifies changes and reports them on valid/ready.
// Optional stability filter: define LATCH_READER_FILTER_EN to include the QUAL state and counter.
module latch_bank_reader #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] q_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_changed,
  output logic             overrun
);

  if (WIDTH < 1 || WIDTH > 32 || STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : g_bad_param
    $error("latch_bank_reader: WIDTH or STABLE_CYCLES out of range");
  end

  typedef enum logic [1:0] {IDLE, QUAL, PRESENT} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] sync1, sync2, prev_sync2;
  logic [WIDTH-1:0] last_rep, last_rep_d;
  logic [WIDTH-1:0] data_d, changed_d;
  logic             valid_d, overrun_d;

`ifdef LATCH_READER_FILTER_EN
  localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);
  logic [WIDTH-1:0] candidate, candidate_d;
  logic [7:0]       cnt, cnt_d;
`endif

  always_comb begin
    state_d    = state;
    last_rep_d = last_rep;
    data_d     = out_data;
    changed_d  = out_changed;
    valid_d    = out_valid;
    // A pending-but-unreported sync2 value being replaced means it will never be seen.
    overrun_d  = overrun |
                 ((state == PRESENT) && (sync2 != prev_sync2) && (prev_sync2 != last_rep));
`ifdef LATCH_READER_FILTER_EN
    candidate_d = candidate;
    cnt_d       = cnt;
`endif
    case (state)
      IDLE: begin
        if (sync2 != last_rep) begin
`ifdef LATCH_READER_FILTER_EN
          candidate_d = sync2;
          cnt_d       = 8'd1;
          state_d     = QUAL;
`else
          data_d     = sync2;
          changed_d  = sync2 ^ last_rep;
          last_rep_d = sync2;
          valid_d    = 1'b1;
          state_d    = PRESENT;
`endif
        end
      end
`ifdef LATCH_READER_FILTER_EN
      QUAL: begin
        if (sync2 == last_rep) begin
          state_d = IDLE;
        end else if (sync2 != candidate) begin
          candidate_d = sync2;
          cnt_d       = 8'd1;
        end else if (cnt == STABLE_CNT) begin
          data_d     = candidate;
          changed_d  = candidate ^ last_rep;
          last_rep_d = candidate;
          valid_d    = 1'b1;
          state_d    = PRESENT;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
`endif
      PRESENT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sync1       <= '0;
      sync2       <= '0;
      prev_sync2  <= '0;
      last_rep    <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_changed <= '0;
      overrun     <= 1'b0;
`ifdef LATCH_READER_FILTER_EN
      candidate   <= '0;
      cnt         <= '0;
`endif
    end else begin
      state       <= state_d;
      sync1       <= q_in;
      sync2       <= sync1;
      prev_sync2  <= sync2;
      last_rep    <= last_rep_d;
      out_valid   <= valid_d;
      out_data    <= data_d;
      out_changed <= changed_d;
      overrun     <= overrun_d;
`ifdef LATCH_READER_FILTER_EN
      candidate   <= candidate_d;
      cnt         <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_latch_bank_reader.sv
// tb/tb_latch_bank_reader.sv - randomized and directed checks of latch_bank_reader against a run-length model.
module tb_latch_bank_reader;
  localparam int WIDTH = 4;
  localparam int S     = 3;
`ifdef LATCH_READER_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  // Edges a value must be seen at sync2 while idle, and edges from q_in change to out_valid.
  localparam int NEED = FILT ? S + 1 : 1;
  localparam int LAT  = FILT ? S + 3 : 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] q_in = '0;
  logic             out_valid, overrun;
  logic [WIDTH-1:0] out_data, out_changed;

  latch_bank_reader #(.WIDTH(WIDTH), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .q_in(q_in), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_changed(out_changed), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a delay line for the synchronizer plus a run-length qualifier.
  logic [WIDTH-1:0] m_h1 = '0, m_h2 = '0, m_h3 = '0;
  logic [WIDTH-1:0] m_last = '0, m_data = '0, m_chg = '0, runval = '0;
  logic             m_valid = 1'b0, m_ovr = 1'b0;
  int               run = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_h1 = '0; m_h2 = '0; m_h3 = '0; m_last = '0; m_data = '0; m_chg = '0;
      m_valid = 1'b0; m_ovr = 1'b0; run = 0; runval = '0;
    end else begin
      if (m_valid && m_h2 != m_h3 && m_h3 != m_last) m_ovr = 1'b1;
      if (m_valid) begin
        if (out_ready) m_valid = 1'b0;
      end else if (m_h2 == m_last) begin
        run = 0;
      end else begin
        if (run > 0 && m_h2 == runval) run++;
        else begin
          run = 1;
          runval = m_h2;
        end
        if (run == NEED) begin
          m_valid = 1'b1;
          m_data  = runval;
          m_chg   = runval ^ m_last;
          m_last  = runval;
          run     = 0;
        end
      end
      m_h3 = m_h2; m_h2 = m_h1; m_h1 = q_in;
    end
  end

  always @(negedge clk) begin
    chk("model_valid", 32'(out_valid), 32'(m_valid));
    chk("model_data", 32'(out_data), 32'(m_data));
    chk("model_changed", 32'(out_changed), 32'(m_chg));
    chk("model_overrun", 32'(overrun), 32'(m_ovr));
    if (out_valid) chk("changed_nonzero", 32'(out_changed != '0), 32'd1);
  end

  task automatic do_reset(input logic [WIDTH-1:0] q);
    @(negedge clk);
    rst = 1'b1; q_in = q; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {out_valid, overrun, out_data, out_changed}, '0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic count_to_valid(input string name, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 60);
    if (!out_valid) chk({name, "_timeout"}, 32'(out_valid), 32'd1);
    @(negedge clk);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    bit seen;

    // Reset with 1010 present, then first report latency.
    do_reset(4'b1010);
    count_to_valid("rst_lat", n);
    chk("rst_latency", 32'(n), 32'(LAT));
    chk("rst_data", 32'(out_data), 32'b1010);
    chk("rst_changed", 32'(out_changed), 32'b1010);

    // Backpressure hold, then one handshake and no re-report.
    repeat (10) @(negedge clk);
    chk("hold_valid", 32'(out_valid), 32'd1);
    chk("hold_data", 32'(out_data), 32'b1010);
    handshake();
    chk("hs_valid_low", 32'(out_valid), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("no_rereport", 32'(seen), 32'd0);

    // Two-cycle glitch: rejected only when the filter is present.
    do_reset(4'b0000);
    q_in = 4'b0001;
    repeat (2) @(negedge clk);
    q_in = 4'b0000;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("glitch_seen", 32'(seen), 32'(!FILT));

    // Candidate restart 0011 -> 0111.
    do_reset(4'b0000);
    q_in = 4'b0011;
    repeat (2) @(negedge clk);
    q_in = 4'b0111;
    count_to_valid("restart_lat", n);
    chk("restart_latency", 32'(n), FILT ? 32'(LAT) : 32'd1);
    chk("restart_data", 32'(out_data), FILT ? 32'b0111 : 32'b0011);
    chk("restart_changed", 32'(out_changed), FILT ? 32'b0111 : 32'b0011);

    // Overrun while 1111 is pending.
    do_reset(4'b0000);
    q_in = 4'b1111;
    count_to_valid("ovr_lat", n);
    chk("ovr_first_latency", 32'(n), 32'(LAT));
    q_in = 4'b0001;
    repeat (5) @(negedge clk);
    chk("ovr_not_yet", 32'(overrun), 32'd0);
    q_in = 4'b0010;
    repeat (5) @(negedge clk);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_pending_data", 32'(out_data), 32'b1111);
    handshake();
    count_to_valid("ovr_next", n);
    chk("ovr_next_latency", 32'(n), 32'(NEED));
    chk("ovr_next_data", 32'(out_data), 32'b0010);
    chk("ovr_next_changed", 32'(out_changed), 32'b1101);
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Randomized traffic with occasional reset.
    do_reset(4'b0000);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 4) == 0) q_in = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
